// File: rtl/softmax_backward_if.sv
// Handshake bundle for the softmax backward unit: y/dy vectors in, dx vector out.
// Element i of each vector sits at [i*DATA_WIDTH +: DATA_WIDTH].
interface softmax_backward_if #(
  parameter int DATA_WIDTH = 16,
  parameter int VEC_LEN    = 8
);
  logic [VEC_LEN*DATA_WIDTH-1:0] y_in;
  logic [VEC_LEN*DATA_WIDTH-1:0] dy_in;
  logic                          valid_in;
  logic                          ready_in;
  logic [VEC_LEN*DATA_WIDTH-1:0] dx_out;
  logic                          valid_out;
  logic                          ready_out;

  modport master (
    output y_in, dy_in, valid_in, ready_out,
    input  ready_in, dx_out, valid_out
  );

  modport slave (
    input  y_in, dy_in, valid_in, ready_out,
    output ready_in, dx_out, valid_out
  );
endinterface

// File: rtl/softmax_backward_unit.sv
// Softmax backward pass dx_i = y_i * (dy_i - sum_j dy_j*y_j) for one vector,
// computed sequentially: a DOT phase then a SCALE phase, one element per cycle.
module softmax_backward_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int VEC_LEN    = 8,
  parameter int FRAC_BITS  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  softmax_backward_if.slave  bus
);
  localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int VEC_W  = VEC_LEN * DATA_WIDTH;
  localparam int TERM_W = 2 * DATA_WIDTH + 1;
  localparam int ACC_W  = TERM_W + $clog2(VEC_LEN);
  localparam int DIFF_W = ACC_W + 1;
  localparam int PROD_W = DIFF_W + DATA_WIDTH + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DOT, SCALE, OUTPUT} state_t;

  function automatic logic signed [DATA_WIDTH-1:0] scale_sat(
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W-1:0] shifted;
    shifted = prod >>> FRAC_BITS;
    if (shifted > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (shifted < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return shifted[DATA_WIDTH-1:0];
  endfunction

  state_t                   state, next_state;
  logic [IDX_W-1:0]         idx;
  logic [VEC_W-1:0]         y_p0, dy_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic [VEC_W-1:0]         dx_p2;
  logic                     last;

  logic [DATA_WIDTH-1:0]        y_cur;
  logic signed [DATA_WIDTH-1:0] dy_cur;
  logic signed [TERM_W-1:0]     dy_term, y_term, dot_term;
  logic signed [ACC_W-1:0]      dot_q;
  logic signed [DIFF_W-1:0]     diff;
  logic signed [PROD_W-1:0]     y_wide, diff_wide, prod;

  assign last   = (idx == LAST_IDX);
  assign y_cur  = y_p0[idx*DATA_WIDTH +: DATA_WIDTH];
  assign dy_cur = dy_p0[idx*DATA_WIDTH +: DATA_WIDTH];

  // DOT multiplier: signed gradient times zero-extended probability
  assign dy_term  = TERM_W'(dy_cur);
  assign y_term   = TERM_W'(y_cur);
  assign dot_term = dy_term * y_term;

  // SCALE multiplier: floor-shifted dot product, full-width difference
  assign dot_q     = acc_p1 >>> FRAC_BITS;
  assign diff      = DIFF_W'(dy_cur) - DIFF_W'(dot_q);
  assign y_wide    = PROD_W'(y_cur);
  assign diff_wide = PROD_W'(diff);
  assign prod      = y_wide * diff_wide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.valid_in)  next_state = DOT;
      DOT:     if (last)          next_state = SCALE;
      SCALE:   if (last)          next_state = OUTPUT;
      OUTPUT:  if (bus.ready_out) next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_in  = (state == IDLE);
    bus.valid_out = (state == OUTPUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p0   <= '0;
      dy_p0  <= '0;
      acc_p1 <= '0;
      dx_p2  <= '0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            y_p0   <= bus.y_in;
            dy_p0  <= bus.dy_in;
            acc_p1 <= '0;
            idx    <= '0;
          end
        end
        // stage p1: accumulate dot product
        DOT: begin
          acc_p1 <= acc_p1 + ACC_W'(dot_term);
          idx    <= last ? '0 : idx + 1'b1;
        end
        // stage p2: scale and write one dx element
        SCALE: begin
          dx_p2[idx*DATA_WIDTH +: DATA_WIDTH] <= scale_sat(prod);
          idx <= last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dx_out = dx_p2;
endmodule

// File: tb/tb_softmax_backward_unit.sv
// Scoreboard bench for softmax_backward_unit: expected dx vectors are queued at
// issue time and popped by an independent monitor on each output handshake.
module tb_softmax_backward_unit;
  localparam int DW = 16;
  localparam int VL = 8;
  localparam int FB = 15;
  localparam int VW = DW * VL;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  softmax_backward_if #(.DATA_WIDTH(DW), .VEC_LEN(VL)) bif ();

  softmax_backward_unit #(.DATA_WIDTH(DW), .VEC_LEN(VL), .FRAC_BITS(FB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] mon_exp;

  logic [VW-1:0] y_onehot, dy_onehot, exp_onehot;
  logic [VW-1:0] y_uni, dy_uni0, exp_uni0, dy_uni1, exp_uni1;
  logic [VW-1:0] y_sat, dy_sat, exp_sat;
  logic [VW-1:0] held;
  int a[VL];

  function automatic logic [VW-1:0] pack(input int v[VL]);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < VL; i++) r[i*DW +: DW] = DW'(v[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic send(input logic [VW-1:0] y, input logic [VW-1:0] dy,
                      input logic [VW-1:0] expv, input bit push);
    int n;
    n = 0;
    bif.y_in     = y;
    bif.dy_in    = dy;
    bif.valid_in = 1'b1;
    while (!bif.ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got ready_in=0 expected 1");
    end
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bif.valid_out || !bif.ready_in) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk1(name, n < 300, 1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bif.valid_out && bif.ready_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %h expected none", bif.dx_out);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("dx_vector", bif.dx_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    a = '{32768, 0, 0, 0, 0, 0, 0, 0};                      y_onehot   = pack(a);
    a = '{4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096};  dy_onehot  = pack(a);
    a = '{0, 0, 0, 0, 0, 0, 0, 0};                          exp_onehot = pack(a);
    a = '{4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096};  y_uni      = pack(a);
    a = '{8192, 0, 0, 0, 0, 0, 0, 0};                       dy_uni0    = pack(a);
    a = '{896, -128, -128, -128, -128, -128, -128, -128};   exp_uni0   = pack(a);
    a = '{0, 8192, 0, 0, 0, 0, 0, 0};                       dy_uni1    = pack(a);
    a = '{-128, 896, -128, -128, -128, -128, -128, -128};   exp_uni1   = pack(a);
    a = '{32768, 32768, 0, 0, 0, 0, 0, 0};                  y_sat      = pack(a);
    a = '{32767, -32768, 0, 0, 0, 0, 0, 0};                 dy_sat     = pack(a);
    a = '{32767, -32767, 0, 0, 0, 0, 0, 0};                 exp_sat    = pack(a);

    bif.valid_in  = 1'b0;
    bif.ready_out = 1'b1;
    bif.y_in      = '0;
    bif.dy_in     = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_ready_in", bif.ready_in, 1'b1);
    chk1("reset_valid_out", bif.valid_out, 1'b0);
    chk("reset_dx_out", bif.dx_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // one-hot with latency measurement
    send(y_onehot, dy_onehot, exp_onehot, 1'b1);
    bif.valid_in = 1'b0;
    cyc = 0;
    while (!bif.valid_out && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk_int("latency", cyc, 16);
    wait_drain("drain_onehot");

    send(y_uni, dy_uni0, exp_uni0, 1'b1);
    bif.valid_in = 1'b0;
    wait_drain("drain_uniform");

    send(y_sat, dy_sat, exp_sat, 1'b1);
    bif.valid_in = 1'b0;
    wait_drain("drain_saturation");

    // backpressure with an ignored input pulse during the stall
    bif.ready_out = 1'b0;
    send(y_uni, dy_uni1, exp_uni1, 1'b1);
    bif.valid_in = 1'b0;
    cyc = 0;
    while (!bif.valid_out && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    held = bif.dx_out;
    chk("stall_first_dx", held, exp_uni1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bif.y_in     = y_sat;
        bif.dy_in    = dy_sat;
        bif.valid_in = 1'b1;
      end
      if (i == 2) bif.valid_in = 1'b0;
      @(posedge clk);
      #1;
      chk1("stall_valid_out", bif.valid_out, 1'b1);
      chk1("stall_ready_in", bif.ready_in, 1'b0);
      chk("stall_dx_stable", bif.dx_out, held);
    end
    bif.ready_out = 1'b1;
    @(posedge clk);
    #1;
    chk1("release_valid_out", bif.valid_out, 1'b0);
    chk1("release_ready_in", bif.ready_in, 1'b1);
    wait_drain("drain_stall");

    // back-to-back with valid_in held high
    send(y_onehot, dy_onehot, exp_onehot, 1'b1);
    send(y_uni, dy_uni0, exp_uni0, 1'b1);
    send(y_sat, dy_sat, exp_sat, 1'b1);
    bif.valid_in = 1'b0;
    wait_drain("drain_b2b");

    // reset during the fourth SCALE cycle
    send(y_uni, dy_uni0, exp_uni0, 1'b0);
    bif.valid_in = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("midreset_valid_out", bif.valid_out, 1'b0);
    chk1("midreset_ready_in", bif.ready_in, 1'b1);
    chk("midreset_dx_out", bif.dx_out, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(y_uni, dy_uni0, exp_uni0, 1'b1);
    bif.valid_in = 1'b0;
    wait_drain("drain_after_reset");
    chk_int("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/softmax_backward_unit.md
Name: softmax_backward_unit

Overview:
Computes the softmax gradient (backward pass) for one VEC_LEN-element vector: dx_i = y_i * (dy_i - sum_j(dy_j * y_j)). Here y is the forward softmax output, with 1.0 = 2^FRAC_BITS, and dy is the upstream gradient. The block sits beside the forward softmax in the special-functions group. It accepts y and dy together through a valid/ready handshake and returns dx with its own valid/ready handshake. It uses a sequential multi-cycle datapath with one shared multiplier per phase.

Parameters:
DATA_WIDTH, 16, width of each y, dy and dx element
VEC_LEN, 8, elements per vector (power of two, 2..64)
FRAC_BITS, 15, fractional bits; y scale 1.0 = 2^FRAC_BITS, dy/dx signed fixed point with the same fraction

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
y_in  input  VEC_LEN*DATA_WIDTH  forward outputs, unsigned, element i at [i*DATA_WIDTH +: DATA_WIDTH]
dy_in  input  VEC_LEN*DATA_WIDTH  upstream gradient, signed, same packing
valid_in  input  1  y_in/dy_in valid
ready_in  output  1  block can accept a vector
dx_out  output  VEC_LEN*DATA_WIDTH  input gradient, signed, same packing
valid_out  output  1  dx_out valid
ready_out  input  1  downstream accepts dx_out

Behaviour:
- Reset (async, any state): state=IDLE, ready_in=1, valid_out=0, dx_out=0, accumulator=0, index=0, captured y/dy=0.
- States: IDLE, DOT, SCALE, OUTPUT.
- IDLE:
  - ready_in=1.
  - On a clock edge with valid_in && ready_in, capture all y_in/dy_in into internal registers, clear the accumulator and index, go to DOT, and drop ready_in.
- DOT: one element per cycle, i = 0..VEC_LEN-1.
  - acc += signed(dy_i) * zero-extended(y_i).
  - Accumulator width is 2*DATA_WIDTH+1+log2(VEC_LEN), so it never overflows.
  - After element VEC_LEN-1, reset index to 0 and go to SCALE.
- SCALE: one element per cycle.
  - dot_q = acc >>> FRAC_BITS (arithmetic shift, floor).
  - diff_i = sign-extended(dy_i) - dot_q, full width, no saturation.
  - prod_i = zero-extended(y_i) * diff_i.
  - dx_i = prod_i >>> FRAC_BITS, saturated to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Write dx_i into the dx_out register.
  - After element VEC_LEN-1, go to OUTPUT and set valid_out=1 on the same edge.
- Latency: valid_out first samples high 2*VEC_LEN edges after the accepting edge (16 for VEC_LEN=8).
- OUTPUT:
  - valid_out=1; dx_out holds stable for as long as ready_out=0.
  - On an edge with ready_out=1: valid_out=0, state=IDLE, ready_in=1 from the next cycle.
  - No same-cycle accept of a new vector (one idle bubble minimum).
- ready_in is 0 in DOT, SCALE and OUTPUT. valid_in and input data changes in those states are ignored and have no effect on results.
- dx_out keeps its last value after the handshake until the next SCALE phase overwrites it element by element. Consumers use it only while valid_out=1.
- Reset mid-operation: all state returns to reset values immediately. Any partial result is discarded and no valid_out pulse is produced.
- y values are not required to sum to 1.0. The arithmetic is defined for any unsigned y, and saturation covers the overflow cases.

Test Plan:
- One-hot: y0=32768, others 0; all dy=4096 -> dot_q=4096, every dx=0; valid_out rises exactly 16 cycles after the accept edge.
- Uniform: all y=4096; dy0=8192, others 0 -> dot_q=1024, dx0=896, dx1..dx7=-128 (sum of dx = 0).
- Saturation: y0=y1=32768, others 0; dy0=32767, dy1=-32768 -> dot_q=-1, dx0=32767 (saturated from 32768), dx1=-32767, dx2..7=0.
- Backpressure: hold ready_out=0 for 5 cycles after valid_out rises -> valid_out and dx_out stable, ready_in=0, and a valid_in pulse with new data during the stall is ignored. Release: valid_out drops next edge, ready_in=1 the following cycle.
- Back-to-back: present 3 vectors with valid_in held high and ready_out=1 -> each is accepted only when ready_in=1 and yields correct dx, in order, with no vector lost or duplicated.
- Reset mid-SCALE: drop rst_n at the 4th SCALE cycle -> valid_out=0, ready_in=1, dx_out=0 immediately. After release, a fresh uniform vector yields the uniform-case results.
